// File: rtl/prog_fsm_pkg.sv
// Shared types and helpers for the table-driven programmable Moore FSM.
// Rule record occupies the low RULE_W-1 bits of cfg_wdata; the top bit is reserved.
package prog_fsm_pkg;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int rule_width(input int in_w, input int sw);
    return 2 + 2 * sw + 4 * in_w;
  endfunction

  localparam int DEF_IN_W     = 4;
  localparam int DEF_OUT_W    = 3;
  localparam int DEF_N_STATES = 8;
  localparam int DEF_N_RULES  = 16;
  localparam int DEF_SW       = idx_width(DEF_N_STATES);

  localparam logic CFG_RULE = 1'b0;
  localparam logic CFG_OUT  = 1'b1;

  typedef struct packed {
    logic                    rsvd;
    logic                    valid;
    logic [DEF_SW-1:0]       src;
    logic [DEF_SW-1:0]       dst;
    logic [2*DEF_IN_W-1:0]   match;
    logic [2*DEF_IN_W-1:0]   mask;
  } rule_t;

endpackage

// File: rtl/prog_fsm_if.sv
// Configuration, operand and status bundle of prog_fsm.
// PROG_FSM_TIMEOUT_EN adds to_limit and timeout.
interface prog_fsm_if
  import prog_fsm_pkg::*;
#(
  parameter int IN_W     = DEF_IN_W,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int N_STATES = DEF_N_STATES,
  parameter int N_RULES  = DEF_N_RULES
`ifdef PROG_FSM_TIMEOUT_EN
  , parameter int TO_W   = 8
`endif
) ();
  localparam int SW     = idx_width(N_STATES);
  localparam int RW     = idx_width(N_RULES);
  localparam int AW     = (SW > RW) ? SW : RW;
  localparam int RULE_W = rule_width(IN_W, SW);

  logic              en;
  logic [IN_W-1:0]   a;
  logic [IN_W-1:0]   b;
  logic              cfg_we;
  logic              cfg_sel;
  logic [AW-1:0]     cfg_addr;
  logic [RULE_W-1:0] cfg_wdata;
  logic [OUT_W-1:0]  out;
  logic [SW-1:0]     state_o;
  logic              hit;
  logic [RW-1:0]     hit_idx;
  logic              changed;
`ifdef PROG_FSM_TIMEOUT_EN
  logic [TO_W-1:0]   to_limit;
  logic              timeout;
`endif

  modport master (
    output en, a, b, cfg_we, cfg_sel, cfg_addr, cfg_wdata,
    input  out, state_o, hit, hit_idx, changed
`ifdef PROG_FSM_TIMEOUT_EN
    , output to_limit, input timeout
`endif
  );

  modport slave (
    input  en, a, b, cfg_we, cfg_sel, cfg_addr, cfg_wdata,
    output out, state_o, hit, hit_idx, changed
`ifdef PROG_FSM_TIMEOUT_EN
    , input to_limit, output timeout
`endif
  );

endinterface

// File: rtl/prog_fsm_match.sv
// Combinational rule matcher: lowest-index matching rule wins.
module prog_fsm_match
  import prog_fsm_pkg::*;
#(
  parameter int IN_W     = DEF_IN_W,
  parameter int N_STATES = DEF_N_STATES,
  parameter int N_RULES  = DEF_N_RULES,
  parameter int SW       = idx_width(N_STATES),
  parameter int RW       = idx_width(N_RULES),
  parameter int RB       = rule_width(IN_W, SW) - 1
) (
  input  logic [RB-1:0]   rules [N_RULES],
  input  logic [SW-1:0]   state,
  input  logic [IN_W-1:0] a,
  input  logic [IN_W-1:0] b,
  output logic            hit,
  output logic [RW-1:0]   hit_idx,
  output logic [SW-1:0]   dst
);

  logic [N_RULES-1:0] match_vec;

  // A rule pointing outside the state space never fires.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    match_vec = '0;
    for (int i = 0; i < N_RULES; i++) begin
      match_vec[i] = rules[i][RB-1]
                   && (rules[i][RB-2 -: SW] == state)
                   && ((({a, b} ^ rules[i][4*IN_W-1 -: 2*IN_W]) & rules[i][2*IN_W-1:0]) == '0)
                   && (int'(rules[i][RB-2-SW -: SW]) < N_STATES);
    end
  end

  always_comb begin
    hit     = |match_vec;
    hit_idx = '0;
    dst     = '0;
    for (int i = N_RULES - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        hit_idx = i[RW-1:0];
        dst     = rules[i][RB-2-SW -: SW];
      end
    end
  end

endmodule

// File: rtl/prog_fsm.sv
// Run-time programmable Moore FSM: rule table, output table, state and status flags.
// Optional dwell timeout back to RESET_STATE under PROG_FSM_TIMEOUT_EN.
module prog_fsm
  import prog_fsm_pkg::*;
#(
  parameter int IN_W        = DEF_IN_W,
  parameter int OUT_W       = DEF_OUT_W,
  parameter int N_STATES    = DEF_N_STATES,
  parameter int N_RULES     = DEF_N_RULES,
  parameter int RESET_STATE = 0
`ifdef PROG_FSM_TIMEOUT_EN
  , parameter int TO_W      = 8
`endif
) (
  input logic       clk,
  input logic       rst,
  prog_fsm_if.slave bus
);

  localparam int SW     = idx_width(N_STATES);
  localparam int RW     = idx_width(N_RULES);
  localparam int RULE_W = rule_width(IN_W, SW);
  localparam int RB     = RULE_W - 1;
  localparam logic [SW-1:0] RST_ST = SW'(RESET_STATE);

  logic [RB-1:0]    rules   [N_RULES];
  logic [OUT_W-1:0] out_tbl [N_STATES];
  logic [SW-1:0]    state;
  logic [SW-1:0]    next_state;
  logic             hit_q;
  logic [RW-1:0]    hit_idx_q;
  logic             changed_q;

  logic             m_hit;
  logic [RW-1:0]    m_idx;
  logic [SW-1:0]    m_dst;
  logic             fire;
  logic             to_fire;
  logic             rule_wr;
  logic             out_wr;
  logic             unused_rsvd;

  prog_fsm_match #(
    .IN_W     (IN_W),
    .N_STATES (N_STATES),
    .N_RULES  (N_RULES),
    .SW       (SW),
    .RW       (RW),
    .RB       (RB)
  ) u_match (
    .rules   (rules),
    .state   (state),
    .a       (bus.a),
    .b       (bus.b),
    .hit     (m_hit),
    .hit_idx (m_idx),
    .dst     (m_dst)
  );

  assign fire        = bus.en & m_hit;
  assign rule_wr     = bus.cfg_we && (bus.cfg_sel == CFG_RULE) && (int'(bus.cfg_addr) < N_RULES);
  assign out_wr      = bus.cfg_we && (bus.cfg_sel == CFG_OUT)  && (int'(bus.cfg_addr) < N_STATES);
  assign unused_rsvd = bus.cfg_wdata[RULE_W-1];

`ifdef PROG_FSM_TIMEOUT_EN
  logic [TO_W-1:0] dwell;
  logic            timeout_q;

  // A firing rule always beats the timeout; to_limit == 0 disables it.
  assign to_fire     = bus.en && !m_hit && (bus.to_limit != '0) && (dwell >= bus.to_limit);
  assign bus.timeout = timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= to_fire;
      if (to_fire || (next_state != state)) begin
        dwell <= '0;
      end else if (bus.en && (dwell != '1)) begin
        dwell <= dwell + 1'b1;
      end
    end
  end
`else
  assign to_fire = 1'b0;
`endif

  always_comb begin
    next_state = state;
    if (fire) begin
      next_state = m_dst;
    end else if (to_fire) begin
      next_state = RST_ST;
    end
  end

  // Writes land on the same edge as evaluation, so evaluation sees the old tables.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RST_ST;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
      changed_q <= 1'b0;
      // NOTE: the tables are small register arrays and must read as empty after reset, so they are cleared here rather than left uninitialised like a RAM.
      for (int i = 0; i < N_RULES; i++) rules[i] <= '0;
      for (int i = 0; i < N_STATES; i++) out_tbl[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on pre-edge values.
      state     <= next_state;
      hit_q     <= fire;
      hit_idx_q <= fire ? m_idx : '0;
      changed_q <= (next_state != state);
      if (rule_wr) rules[bus.cfg_addr[RW-1:0]] <= bus.cfg_wdata[RB-1:0];
      if (out_wr)  out_tbl[bus.cfg_addr[SW-1:0]] <= bus.cfg_wdata[OUT_W-1:0];
    end
  end

  assign bus.out     = out_tbl[state];
  assign bus.state_o = state;
  assign bus.hit     = hit_q;
  assign bus.hit_idx = hit_idx_q;
  assign bus.changed = changed_q;

endmodule

// File: tb/tb_prog_fsm.sv
// Self-checking bench for prog_fsm: directed scenarios plus randomized traffic
// compared against a rule-list reference model.
module tb_prog_fsm;
  import prog_fsm_pkg::*;

  localparam int IN_W     = DEF_IN_W;
  localparam int OUT_W    = DEF_OUT_W;
  localparam int N_STATES = DEF_N_STATES;
  localparam int N_RULES  = DEF_N_RULES;
  localparam int SW       = DEF_SW;
  localparam int RW       = idx_width(N_RULES);
  localparam int AW       = (SW > RW) ? SW : RW;
  localparam int RULE_W   = rule_width(IN_W, SW);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prog_fsm_if #(.IN_W(IN_W), .OUT_W(OUT_W), .N_STATES(N_STATES), .N_RULES(N_RULES)) bus ();

  prog_fsm #(.IN_W(IN_W), .OUT_W(OUT_W), .N_STATES(N_STATES), .N_RULES(N_RULES),
             .RESET_STATE(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model state
  rule_t            m_rules [N_RULES];
  logic [OUT_W-1:0] m_out   [N_STATES];
  int               m_state;
  bit               m_hit;
  int               m_idx;
  bit               m_changed;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic rule_t mk(input bit v, input logic [SW-1:0] src, input logic [SW-1:0] dst,
                               input logic [IN_W-1:0] ma, input logic [IN_W-1:0] mb,
                               input logic [IN_W-1:0] ka, input logic [IN_W-1:0] kb);
    rule_t r;
    r       = '0;
    r.valid = v;
    r.src   = src;
    r.dst   = dst;
    r.match = {ma, mb};
    r.mask  = {ka, kb};
    return r;
  endfunction

  // First rule in list order that applies, or -1.
  function automatic int model_pick(input int st, input logic [IN_W-1:0] a, input logic [IN_W-1:0] b);
    for (int i = 0; i < N_RULES; i++) begin
      if (m_rules[i].valid && int'(m_rules[i].src) == st &&
          ((({a, b} ^ m_rules[i].match) & m_rules[i].mask) == '0) &&
          int'(m_rules[i].dst) < N_STATES)
        return i;
    end
    return -1;
  endfunction

  // Advance the model with the currently driven inputs, clock once, compare.
  task automatic tick();
    int k;
    int prev;
    if (rst) begin
      m_state   = 0;
      m_hit     = 0;
      m_idx     = 0;
      m_changed = 0;
      for (int i = 0; i < N_RULES; i++) m_rules[i] = '0;
      for (int i = 0; i < N_STATES; i++) m_out[i] = '0;
    end else begin
      k    = bus.en ? model_pick(m_state, bus.a, bus.b) : -1;
      prev = m_state;
      m_hit = (k >= 0);
      if (m_hit) begin
        m_idx   = k;
        m_state = int'(m_rules[k].dst);
      end
      m_changed = (m_state != prev);
      if (bus.cfg_we) begin
        if (bus.cfg_sel == CFG_RULE) begin
          if (int'(bus.cfg_addr) < N_RULES) m_rules[int'(bus.cfg_addr)] = rule_t'(bus.cfg_wdata);
        end else begin
          if (int'(bus.cfg_addr) < N_STATES) m_out[int'(bus.cfg_addr)] = bus.cfg_wdata[OUT_W-1:0];
        end
      end
    end
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
    check("state", 32'(bus.state_o), m_state);
    check("out", 32'(bus.out), 32'(m_out[m_state]));
    check("hit", 32'(bus.hit), 32'(m_hit));
    check("changed", 32'(bus.changed), 32'(m_changed));
    if (m_hit) check("hit_idx", 32'(bus.hit_idx), m_idx);
  endtask

  task automatic wr_rule(input int idx, input rule_t r);
    bus.cfg_we    = 1'b1;
    bus.cfg_sel   = CFG_RULE;
    bus.cfg_addr  = AW'(idx);
    bus.cfg_wdata = r;
    tick();
  endtask

  task automatic wr_out(input int idx, input int v);
    bus.cfg_we    = 1'b1;
    bus.cfg_sel   = CFG_OUT;
    bus.cfg_addr  = AW'(idx);
    bus.cfg_wdata = RULE_W'(v);
    tick();
  endtask

  initial begin
    rule_t r;
    rst           = 1'b1;
    bus.en        = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cfg_we    = 1'b0;
    bus.cfg_sel   = CFG_RULE;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;
`ifdef PROG_FSM_TIMEOUT_EN
    bus.to_limit  = '0;
`endif
    tick();
    tick();
    check("rst_state", 32'(bus.state_o), 0);
    check("rst_out", 32'(bus.out), 0);
    check("rst_hit_idx", 32'(bus.hit_idx), 0);
    rst = 1'b0;

    // Basic program: 0 -> 1 on {10,9}, 1 -> 2 unconditionally
    wr_rule(0, mk(1'b1, 3'd0, 3'd1, 4'd10, 4'd9, 4'hF, 4'hF));
    wr_rule(1, mk(1'b1, 3'd1, 3'd2, 4'd0, 4'd0, 4'h0, 4'h0));
    wr_out(0, 1);
    wr_out(1, 2);
    wr_out(2, 3);
    wr_out(8, 7);
    check("oob_out_ignored", 32'(bus.out), 1);

    bus.en = 1'b1; bus.a = 4'd10; bus.b = 4'd9;
    tick();
    check("seq_s1", 32'(bus.state_o), 1);
    check("seq_out2", 32'(bus.out), 2);
    check("seq_idx0", 32'(bus.hit_idx), 0);
    tick();
    check("seq_s2", 32'(bus.state_o), 2);
    check("seq_out3", 32'(bus.out), 3);
    check("seq_idx1", 32'(bus.hit_idx), 1);
    tick();
    check("nomatch_hit", 32'(bus.hit), 0);
    check("nomatch_chg", 32'(bus.changed), 0);

    // Priority, self-loop and return paths
    bus.en = 1'b0;
    wr_rule(3, mk(1'b1, 3'd2, 3'd4, 4'd0, 4'd0, 4'h0, 4'h0));
    wr_rule(5, mk(1'b1, 3'd2, 3'd6, 4'd10, 4'd9, 4'hF, 4'hF));
    wr_rule(2, mk(1'b1, 3'd4, 3'd4, 4'd3, 4'd0, 4'hF, 4'h0));
    wr_rule(6, mk(1'b1, 3'd4, 3'd0, 4'd0, 4'd0, 4'h0, 4'h0));
    check("en0_state", 32'(bus.state_o), 2);
    check("en0_hit", 32'(bus.hit), 0);
    bus.en = 1'b1;
    tick();
    check("prio_state", 32'(bus.state_o), 4);
    check("prio_idx", 32'(bus.hit_idx), 3);
    bus.a = 4'd3;
    tick();
    check("self_hit", 32'(bus.hit), 1);
    check("self_chg", 32'(bus.changed), 0);
    check("self_state", 32'(bus.state_o), 4);
    bus.a = 4'd10;
    tick();
    check("back_state", 32'(bus.state_o), 0);

    // Same-cycle invalidate of the rule that fires
    wr_rule(0, mk(1'b0, 3'd0, 3'd1, 4'd10, 4'd9, 4'hF, 4'hF));
    check("samecyc_state", 32'(bus.state_o), 1);
    check("samecyc_idx", 32'(bus.hit_idx), 0);
    tick();
    tick();
    tick();
    check("loop_state0", 32'(bus.state_o), 0);
    tick();
    check("dead_rule_state", 32'(bus.state_o), 0);
    check("dead_rule_hit", 32'(bus.hit), 0);

    // Mid-run reset from state 2 discards the tables
    wr_rule(0, mk(1'b1, 3'd0, 3'd1, 4'd10, 4'd9, 4'hF, 4'hF));
    tick();
    tick();
    check("pre_rst_state", 32'(bus.state_o), 2);
    rst = 1'b1;
    tick();
    check("midrst_state", 32'(bus.state_o), 0);
    check("midrst_out", 32'(bus.out), 0);
    rst = 1'b0;
    tick();
    check("post_rst_state", 32'(bus.state_o), 0);
    check("post_rst_hit", 32'(bus.hit), 0);

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      rst     = ($urandom_range(0, 99) == 0);
      bus.en  = ($urandom_range(0, 9) < 8);
      bus.a   = IN_W'($urandom_range(0, 3));
      bus.b   = IN_W'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        bus.cfg_we   = 1'b1;
        bus.cfg_sel  = ($urandom_range(0, 1) == 1) ? CFG_OUT : CFG_RULE;
        bus.cfg_addr = AW'($urandom_range(0, 15));
        if (bus.cfg_sel == CFG_RULE) begin
          r       = rule_t'(RULE_W'($urandom));
          r.valid = ($urandom_range(0, 3) != 0);
          r.src   = SW'($urandom_range(0, 3));
          r.match = {IN_W'($urandom_range(0, 3)), IN_W'($urandom_range(0, 3))};
          case ($urandom_range(0, 2))
            0:       r.mask = '0;
            1:       r.mask = '1;
            default: r.mask = (2*IN_W)'($urandom);
          endcase
          bus.cfg_wdata = r;
        end else begin
          bus.cfg_wdata = RULE_W'($urandom);
        end
      end
      tick();
    end
    rst = 1'b0;

`ifdef PROG_FSM_TIMEOUT_EN
    begin
      int  dwell;
      bit  left;
      rst = 1'b1; bus.en = 1'b0; bus.cfg_we = 1'b0;
      tick();
      rst = 1'b0;
      wr_rule(0, mk(1'b1, 3'd0, 3'd1, 4'd10, 4'd9, 4'hF, 4'hF));
      bus.to_limit = 8'd5;
      bus.en = 1'b1; bus.a = 4'd10; bus.b = 4'd9;
      @(posedge clk); #1;
      check("to_enter", 32'(bus.state_o), 1);
      bus.a = 4'd0; bus.b = 4'd0;
      dwell = 0;
      left  = 1'b0;
      for (int c = 0; c < 20 && !left; c++) begin
        @(posedge clk); #1;
        if (bus.state_o == 3'd1) begin
          dwell++;
          check("to_quiet", 32'(bus.timeout), 0);
        end else begin
          left = 1'b1;
        end
      end
      check("to_dwell", dwell, 5);
      check("to_state", 32'(bus.state_o), 0);
      check("to_pulse", 32'(bus.timeout), 1);
      @(posedge clk); #1;
      check("to_pulse_end", 32'(bus.timeout), 0);
      bus.to_limit = '0;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_fsm.md
# prog_fsm

Table-driven, run-time programmable Moore state machine; the parametrised successor to the hand-coded three-state controllers in this codebase. Transition rules (source state, masked match on inputs A/B, destination) and per-state output words are loaded through a configuration port instead of being fixed in RTL. It sits between the generator's configuration interface and the datapath it controls.

## Interface
- IN_W, 4: width of each input operand A and B
- OUT_W, 3: width of the per-state output word
- N_STATES, 8: number of states, at least 2; SW = $clog2(N_STATES)
- N_RULES, 16: number of transition rules, at least 1; RW = $clog2(N_RULES)
- RESET_STATE, 0: state entered on reset
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  evaluate rules this cycle; when 0 the state holds
- a  in  IN_W  input operand A
- b  in  IN_W  input operand B
- cfg_we  in  1  configuration write strobe
- cfg_sel  in  1  0 = rule table, 1 = output table
- cfg_addr  in  max(RW,SW)  rule index or state index
- cfg_wdata  in  RULE_W  rule record, or output word in the low OUT_W bits
- out  out  OUT_W  output word of the current state (Moore)
- state_o  out  SW  current state
- hit  out  1  a rule fired on the last clock edge
- hit_idx  out  RW  index of the rule that fired
- changed  out  1  one-cycle pulse: the state differs from the previous cycle

## Operation
- Rule record, MSB to LSB: valid(1), src(SW), dst(SW), match(2·IN_W), mask(2·IN_W); RULE_W = 2 + 2·SW + 4·IN_W. Match and mask are laid out as {A,B}.
- A rule matches when valid is set, src == state, and (({a,b} ^ match) & mask) == 0. A mask of 0 is an unconditional rule.
- Priority: the lowest-index matching rule wins. With no match, the state holds and hit is 0.
- A rule whose dst ≥ N_STATES is treated as non-matching and never fires.
- out = out_tbl[state], combinational from the state register. No other logic lies in the path.
- cfg writes commit on the clock edge. A rule index ≥ N_RULES or a state index ≥ N_STATES is ignored.
- Same-cycle cfg write and evaluation: evaluation uses the table contents from before the write.
- cfg writes are accepted regardless of en.

## Timing
- Reset:
  - state = RESET_STATE
  - all rule valid bits = 0
  - all out_tbl entries = 0
  - hit = 0, hit_idx = 0, changed = 0
  - out therefore reads 0
- rst has priority over en and cfg_we. Reset mid-run returns to RESET_STATE on the next edge and discards the table.
- Latency: inputs sampled at edge N set state at N+1; out, state_o, hit and hit_idx are valid in the same cycle as the new state.
- hit is registered and aligned with the transition it caused. It is also set for a matching self-loop (dst == src); changed is not set in that case.
- en = 0: the state holds, hit = 0, changed = 0.

## Configuration
- PROG_FSM_TIMEOUT_EN defined:
  - adds parameter TO_W (default 8), input to_limit[TO_W] and output timeout (1).
  - a dwell counter resets on every state change and on reset, and counts cycles while en = 1.
  - when the count reaches to_limit (nonzero) with no rule firing, the next edge forces state = RESET_STATE and pulses timeout for one cycle.
  - a firing rule takes priority over a timeout in the same cycle.
  - to_limit = 0 disables the timeout.
- PROG_FSM_TIMEOUT_EN undefined: no counter, no extra ports, no timeout path.

## Structure
- Package prog_fsm_pkg holds:
  - the rule record packed-struct typedef (parametrised via localparam widths)
  - the cfg_sel encoding constants CFG_RULE and CFG_OUT
  - a width helper function for RULE_W
- Sub-module prog_fsm_match: purely combinational. Takes the rule table, state, a and b; returns hit, hit_idx and dst using a priority encoder. The top level holds the tables, state register, status flags and timeout.

## Test plan
- Reset, then program rule0 = {src 0, dst 1, match {A=10,B=9}, full mask} and rule1 = {src 1, dst 2, mask 0}; out_tbl = {1,2,3} for states 0..2. Drive a=10, b=9, en=1 → state 0→1→2 on consecutive edges; out = 1,2,3; hit_idx = 0 then 1.
- Priority: rules 3 and 5 both match from state 2 with dst 4 and 6 → state 4, hit_idx = 3.
- No match, or en = 0 → state holds, hit = 0, changed = 0. A matching self-loop → hit = 1, changed = 0.
- In the same cycle, write rule0 with valid = 0 while it matches → the transition still occurs. It does not recur after returning to state 0.
- Assert rst mid-run from state 2 → next cycle state = 0, out = 0, and previously matching inputs cause no transition.
- With PROG_FSM_TIMEOUT_EN and to_limit = 5, hold in state 1 with no matching rule → state returns to 0 after 5 dwell cycles, with a single-cycle timeout pulse.
